// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: control-word layout,
// FSM state encodings, instruction-class patterns and the fetch word.
package cpu_ctrl_pkg;

  localparam int unsigned CW_WIDTH = 100;

  // Control-word field bit positions, LSB first
  localparam int unsigned DA_LSB      = 0;
  localparam int unsigned DA_MSB      = 4;
  localparam int unsigned AA_LSB      = 5;
  localparam int unsigned AA_MSB      = 9;
  localparam int unsigned BA_LSB      = 10;
  localparam int unsigned BA_MSB      = 14;
  localparam int unsigned FS_LSB      = 15;
  localparam int unsigned FS_MSB      = 19;
  localparam int unsigned PS_LSB      = 20;
  localparam int unsigned PS_MSB      = 21;
  localparam int unsigned EN_STAT_BIT = 22;
  localparam int unsigned CS_BIT      = 23;
  localparam int unsigned O_EN_BIT    = 24;
  localparam int unsigned W_EN_BIT    = 25;
  localparam int unsigned PC_SEL_BIT  = 26;
  localparam int unsigned B_SEL_BIT   = 27;
  localparam int unsigned EN_PCA_BIT  = 28;
  localparam int unsigned EN_PC_BIT   = 29;
  localparam int unsigned EN_ADDR_BIT = 30;
  localparam int unsigned EN_B_BIT    = 31;
  localparam int unsigned EN_ALU_BIT  = 32;
  localparam int unsigned IL_BIT      = 33;
  localparam int unsigned WR_BIT      = 34;
  localparam int unsigned K_LSB       = 35;
  localparam int unsigned K_MSB       = 98;
  localparam int unsigned NSTATE_BIT  = 99;

  typedef logic [CW_WIDTH-1:0] cw_t;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Class patterns on instr[28:25]: a class matches when (cls & MASK) == VAL
  localparam logic [3:0] PAT_IMM_VAL  = 4'b1000;
  localparam logic [3:0] PAT_IMM_MASK = 4'b1110;
  localparam logic [3:0] PAT_BR_VAL   = 4'b1010;
  localparam logic [3:0] PAT_BR_MASK  = 4'b1110;
  localparam logic [3:0] PAT_DT_VAL   = 4'b0100;
  localparam logic [3:0] PAT_DT_MASK  = 4'b0101;
  localparam logic [3:0] PAT_REG_VAL  = 4'b0101;
  localparam logic [3:0] PAT_REG_MASK = 4'b0111;

  // Fetch cycle: only the instruction-register load is asserted
  localparam cw_t IL_ONLY = cw_t'(1) << IL_BIT;

  function automatic logic class_match(input logic [3:0] cls,
                                       input logic [3:0] val,
                                       input logic [3:0] mask);
    return (cls & mask) == val;
  endfunction

endpackage

// File: rtl/cpu_class_select.sv
// Instruction-class decode: picks one of the four decoder control words
// from instr[28:25] and flags classes that match no pattern.
module cpu_class_select
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cls_i,
  input  cw_t        cw_dt_i,
  input  cw_t        cw_imm_i,
  input  cw_t        cw_reg_i,
  input  cw_t        cw_br_i,
  output cw_t        cw_o,
  output logic       illegal_o
);

  // 4:1 word mux; the patterns are disjoint so the order is not significant
  always_comb begin
    cw_o      = '0;
    illegal_o = 1'b0;
    if (class_match(cls_i, PAT_IMM_VAL, PAT_IMM_MASK)) begin
      cw_o = cw_imm_i;
    end else if (class_match(cls_i, PAT_BR_VAL, PAT_BR_MASK)) begin
      cw_o = cw_br_i;
    end else if (class_match(cls_i, PAT_DT_VAL, PAT_DT_MASK)) begin
      cw_o = cw_dt_i;
    end else if (class_match(cls_i, PAT_REG_VAL, PAT_REG_MASK)) begin
      cw_o = cw_reg_i;
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle CPU control sequencer: BOOT -> FETCH -> EXEC1 [-> EXEC2] -> FETCH,
// stalling on data-memory handshakes and counting retired instructions.
// Optional build macro STALL_TIMEOUT_EN bounds each stall to MEM_TIMEOUT
// cycles, halting with a sticky mem_fault when it expires.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         instr,
  input  logic [CW_WIDTH-1:0] cw_dt,
  input  logic [CW_WIDTH-1:0] cw_imm,
  input  logic [CW_WIDTH-1:0] cw_reg,
  input  logic [CW_WIDTH-1:0] cw_br,
  input  logic                mem_ready,
  output logic [CW_WIDTH-1:0] ctrl_word,
  output logic                exec_phase,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [31:0]         instr_count,
  output logic                mem_fault
);

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  cw_t         sel_cw;
  logic        sel_illegal;
  logic        unused_instr_bits;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 16) ? 4 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
`endif

  assign unused_instr_bits = ^{instr[31:29], instr[24:0]};

  cpu_class_select u_class_select (
    .cls_i     (instr[28:25]),
    .cw_dt_i   (cw_dt),
    .cw_imm_i  (cw_imm),
    .cw_reg_i  (cw_reg),
    .cw_br_i   (cw_br),
    .cw_o      (sel_cw),
    .illegal_o (sel_illegal)
  );

  // State and retirement counter, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

`ifdef STALL_TIMEOUT_EN
  // Stall-cycle counter and sticky fault flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end
`endif

  // Next state, control-word shaping and stall masking
  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    ctrl_word     = '0;
    illegal       = 1'b0;
`ifdef STALL_TIMEOUT_EN
    wait_d        = wait_q;
    fault_d       = fault_q;
`endif
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl_word = IL_ONLY;
        state_d   = ST_EXEC1;
      end
      ST_EXEC1, ST_EXEC2: begin
        if ((state_q == ST_EXEC1) && sel_illegal) begin
          // Illegal wins over any stall; the word stays zero this cycle
          illegal = 1'b1;
          state_d = ST_HALT;
        end else begin
          ctrl_word         = sel_cw;
          ctrl_word[IL_BIT] = 1'b0;
          if (sel_cw[CS_BIT] && !mem_ready) begin
            // Hold the state and suppress every architectural side effect
            ctrl_word[PS_MSB:PS_LSB] = '0;
            ctrl_word[EN_STAT_BIT]   = 1'b0;
            ctrl_word[W_EN_BIT]      = 1'b0;
            ctrl_word[WR_BIT]        = 1'b0;
`ifdef STALL_TIMEOUT_EN
            if (wait_q == WAIT_LAST) begin
              state_d = ST_HALT;
              fault_d = 1'b1;
            end else begin
              wait_d = wait_q + 1'b1;
            end
`endif
          end else if ((state_q == ST_EXEC1) && sel_cw[NSTATE_BIT]) begin
            state_d = ST_EXEC2;
          end else begin
            state_d       = ST_FETCH;
            instr_count_d = instr_count_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
`ifdef STALL_TIMEOUT_EN
    if (state_d != state_q) begin
      wait_d = '0;
    end
`endif
  end

  assign state       = state_q;
  assign exec_phase  = (state_q == ST_EXEC2);
  assign instr_count = instr_count_q;

`ifdef STALL_TIMEOUT_EN
  assign mem_fault = fault_q;
`else
  // Stalls are unbounded in this build; MEM_TIMEOUT is accepted but inert.
  localparam bit TIMEOUT_CFG = (MEM_TIMEOUT != 0);
  assign mem_fault = 1'b0 & TIMEOUT_CFG;
`endif

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Multi-cycle control sequencer for the CPU datapath. It fetches the instruction and classifies it. It then drives the 100-bit control word from one of four class decoders: data transfer, immediate ALU, register ALU, branch. It stalls on memory handshakes and sequences two-phase instructions. It sits between the instruction register / class decoders and the datapath control inputs.

Parameters:
CW_WIDTH, 100, control word width (layout fixed in package)
MEM_TIMEOUT, 15, max wait cycles for mem_ready (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  32  current instruction register contents
cw_dt  in  100  data-transfer decoder control word
cw_imm  in  100  immediate-ALU decoder control word
cw_reg  in  100  register-ALU decoder control word
cw_br  in  100  branch decoder control word
mem_ready  in  1  data memory access complete this cycle
ctrl_word  out  100  control word to datapath
exec_phase  out  1  0 = first execute phase, 1 = second; fed back to decoders
state  out  3  current FSM state encoding
illegal  out  1  one-cycle pulse on unrecognised instruction class
instr_count  out  32  retired-instruction counter
mem_fault  out  1  sticky memory timeout flag (optional feature only; else tied 0)

Behaviour:
- Control word layout, LSB first:
  - DA 4:0, AA 9:5, BA 14:10, FS 19:15, PS 21:20
  - En_Stat 22, CS 23, O_En 24, W_En 25, PC_SEL 26, B_SEL 27, En_PC_Addr 28, En_PC 29
  - En_Addr 30, En_B 31, En_ALU 32, IL 33, WR 34, K 98:35, NState 99
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low: clock and reset_n.
  - State register and counter are asynchronously cleared.
  - ctrl_word is combinational from state and inputs.
- Reset values: state=BOOT, ctrl_word=0, exec_phase=0, illegal=0, instr_count=0, mem_fault=0.
- States:
  - BOOT(0): ctrl_word=0. Next: FETCH.
  - FETCH(1):
    - ctrl_word=0 except IL=1.
    - Next: EXEC1.
  - EXEC1(2):
    - Class select on instr[28:25]:
      - 100x -> cw_imm
      - 101x -> cw_br
      - x1x0 -> cw_dt
      - x101 -> cw_reg
      - else illegal
    - Output is the selected word with IL forced 0.
  - EXEC2(3): same selection. exec_phase=1. NState ignored.
  - HALT(4): ctrl_word=0. Exits only via reset.
- Illegal class in EXEC1:
  - illegal pulses for 1 cycle.
  - Next: HALT.
  - ctrl_word=0 during that cycle.
- Memory stall (EXEC1 or EXEC2), when selected CS=1 and mem_ready=0:
  - Remain in the state.
  - Force WR=0, W_En=0, PS=00, En_Stat=0 (no architectural side effects).
  - All other fields pass through.
- Commit: CS=0, or CS=1 with mem_ready=1.
  - Fields pass unmodified.
  - In EXEC1 with NState=1 -> EXEC2.
  - Otherwise -> FETCH, and instr_count increments (wraps 2^32-1 -> 0).
- Precedence: reset beats everything; illegal beats stall. mem_ready is sampled only when CS=1.
- Reset mid-instruction: abandon immediately; return to BOOT, count cleared.

Optional Feature:
- Macro: STALL_TIMEOUT_EN.
- Defined:
  - A 4-bit+ wait counter clears on every state change and counts stall cycles.
  - When stall count reaches MEM_TIMEOUT without mem_ready -> HALT; mem_fault set (sticky until reset).
  - mem_ready arriving on the timeout cycle wins: commit.
- Undefined: no counter; stall unbounded; mem_fault tied 0.

Decomposition:
- Package cpu_ctrl_pkg:
  - CW_WIDTH
  - field bit-index localparams for every control-word field
  - state encodings BOOT/FETCH/EXEC1/EXEC2/HALT
  - class-pattern constants
  - IL_ONLY fetch word constant
- Sub-module cpu_class_select: combinational instr[28:25] -> 4:1 word mux plus illegal flag.
- FSM, stall masking and counter live in the top.

Test Plan:
- Reset release, then a load:
  - Pull reset_n low mid-EXEC1 -> state=BOOT, ctrl_word=0, instr_count=0 immediately.
  - Release, then instr=0xF8400000, mem_ready=1 -> states BOOT, FETCH (IL=1), EXEC1 (cw_dt passed, IL=0).
  - After that: FETCH; instr_count=1.
- Store with 3-cycle stall:
  - Stimulus: instr=0xF8000000, cw_dt CS=1, WR=0, mem_ready low 3 cycles.
  - Expect EXEC1 held 4 cycles, PS=00, W_En=0 on the first 3 cycles. Full word on the 4th; then FETCH; count +1.
- Two-phase:
  - Stimulus: cw_imm NState=1 in phase 0.
  - Expect EXEC1 -> EXEC2 with exec_phase=1; count increments only after EXEC2.
- Illegal:
  - Stimulus: instr[28:25]=0000.
  - Expect illegal=1 for one cycle, then HALT with ctrl_word=0 held; no count increment.
- Counter wrap: preload via 2^32-1 retirements (force) -> next commit reads 0.
- STALL_TIMEOUT_EN defined:
  - Stimulus: mem_ready held 0.
  - Expect HALT after 15 stall cycles, mem_fault=1.
  - With mem_ready=1 on cycle 15 -> commit, no fault.
